// File: rtl/vsfx_pkg.sv
// Shared types and constants for the VSFX halfword issue arbiter.
package vsfx_pkg;

  localparam int LANE_W = 16;

  localparam logic [LANE_W-1:0] SAT_MAX = 16'h7fff;
  localparam logic [LANE_W-1:0] SAT_MIN = 16'h8000;

  // Encoding 3'd7 is deliberately unnamed: it is the illegal opcode.
  typedef enum logic [2:0] {
    VSFX_AVGSH  = 3'd0,
    VSFX_AVGUH  = 3'd1,
    VSFX_ADDSHS = 3'd2,
    VSFX_SUBSHS = 3'd3,
    VSFX_MAXSH  = 3'd4,
    VSFX_MINSH  = 3'd5,
    VSFX_ADDUHM = 3'd6
  } vsfx_op_e;

  typedef struct packed {
    logic [LANE_W-1:0] v;
    logic              sat;
  } lane_res_t;

endpackage

// File: rtl/vsfx_lane_alu.sv
// One 16-bit VSFX lane: combinational average / saturating add-sub / max-min / modulo add.
module vsfx_lane_alu
  import vsfx_pkg::*;
(
  input  logic [2:0]        op_i,
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  output lane_res_t         res_o
);

  logic [16:0] sa, sb;
  logic [16:0] add_s, sub_s, avg_s, avg_u;
  logic        unused_lsb;

  assign sa    = {a_i[15], a_i};
  assign sb    = {b_i[15], b_i};
  assign add_s = sa + sb;
  assign sub_s = sa - sb;
  // 17 bits hold a+b+1 for both signednesses, so the average never wraps.
  assign avg_s = sa + sb + 17'd1;
  assign avg_u = {1'b0, a_i} + {1'b0, b_i} + 17'd1;

  assign unused_lsb = avg_s[0] ^ avg_u[0];

  always_comb begin
    res_o = '0;
    case (op_i)
      VSFX_AVGSH:  res_o.v = avg_s[16:1];
      VSFX_AVGUH:  res_o.v = avg_u[16:1];
      VSFX_ADDSHS: begin
        if (add_s[16] != add_s[15]) begin
          res_o.v   = add_s[16] ? SAT_MIN : SAT_MAX;
          res_o.sat = 1'b1;
        end else begin
          res_o.v = add_s[15:0];
        end
      end
      VSFX_SUBSHS: begin
        if (sub_s[16] != sub_s[15]) begin
          res_o.v   = sub_s[16] ? SAT_MIN : SAT_MAX;
          res_o.sat = 1'b1;
        end else begin
          res_o.v = sub_s[15:0];
        end
      end
      VSFX_MAXSH:  res_o.v = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
      VSFX_MINSH:  res_o.v = ($signed(a_i) < $signed(b_i)) ? a_i : b_i;
      VSFX_ADDUHM: res_o.v = a_i + b_i;
      default:     res_o   = '0;
    endcase
  end

endmodule

// File: rtl/vsfx_issue_arb.sv
// Two-requester round-robin front end for a shared VSFX halfword datapath,
// with a registered valid/ready result port and a sticky saturation flag.
module vsfx_issue_arb
  import vsfx_pkg::*;
#(
  parameter int W    = 32,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2:0]      req_op0,
  input  logic [2:0]      req_op1,
  input  logic [W-1:0]    vra0,
  input  logic [W-1:0]    vrb0,
  input  logic [W-1:0]    vra1,
  input  logic [W-1:0]    vrb1,
  input  logic [TAGW-1:0] tag0,
  input  logic [TAGW-1:0] tag1,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_vrt,
  output logic [TAGW-1:0] out_tag,
  output logic            out_src,
  output logic            sat,
  input  logic            sat_clr
);

  localparam int LANES = W / LANE_W;

  logic            ptr_q,   ptr_d;
  logic            valid_q, valid_d;
  logic [W-1:0]    vrt_q,   vrt_d;
  logic [TAGW-1:0] tag_q,   tag_d;
  logic            src_q,   src_d;
  logic            sat_q,   sat_d;

  logic [1:0]      grant;
  logic            free;
  logic            accept;
  logic            sel;
  logic [2:0]      op_s;
  logic [W-1:0]    vra_s, vrb_s, res_vrt;
  logic [TAGW-1:0] tag_s;
  logic [LANES-1:0] lane_sat;
  lane_res_t       lane_res [LANES];

  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Handshake: a transfer happens on any rising edge where valid & ready are
  // both high. Requesters must hold valid and payload until ready; the result
  // port holds out_vrt/out_tag/out_src stable while out_valid & !out_ready.
  assign free      = !valid_q | out_ready;
  assign req_ready = grant & {2{free & rst_n}};
  assign accept    = |req_ready;
  assign sel       = grant[1];

  assign op_s  = sel ? req_op1 : req_op0;
  assign vra_s = sel ? vra1    : vra0;
  assign vrb_s = sel ? vrb1    : vrb0;
  assign tag_s = sel ? tag1    : tag0;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vsfx_lane_alu u_alu (
      .op_i  (op_s),
      .a_i   (vra_s[g*LANE_W +: LANE_W]),
      .b_i   (vrb_s[g*LANE_W +: LANE_W]),
      .res_o (lane_res[g])
    );
    assign res_vrt[g*LANE_W +: LANE_W] = lane_res[g].v;
    assign lane_sat[g]                 = lane_res[g].sat;
  end

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    vrt_d   = vrt_q;
    tag_d   = tag_q;
    src_d   = src_q;
    sat_d   = sat_q;
    if (accept) begin
      ptr_d   = ~sel;
      valid_d = 1'b1;
      vrt_d   = res_vrt;
      tag_d   = tag_s;
      src_d   = sel;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    // A new saturation in the same cycle as a clear must survive.
    if (sat_clr) sat_d = 1'b0;
    if (accept && (|lane_sat)) sat_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= 1'b0;
      valid_q <= 1'b0;
      vrt_q   <= '0;
      tag_q   <= '0;
      src_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      vrt_q   <= vrt_d;
      tag_q   <= tag_d;
      src_q   <= src_d;
      sat_q   <= sat_d;
    end
  end

  assign out_valid = valid_q;
  assign out_vrt   = vrt_q;
  assign out_tag   = tag_q;
  assign out_src   = src_q;
  assign sat       = sat_q;

endmodule
